hgrn_recurrence_unit: RTL and testbench

- Element-wise HGRN token-mixer recurrence. Sits directly downstream of sigmoid_unit, which it instantiates on its forget-gate input path.
- Per channel c it computes h[c] = f*h_prev[c] + (1-f)*c_in, where f = sigmoid(f_pre).
- Hidden state for D channels is held in an internal register file.
- Streams tokens channel-major over a valid/ready interface. Uses the codebase's signed Q(N-R).R fixed-point format.

---
 rtl/hgrn_recurrence_unit_pkg.sv | 22 ++
 rtl/hgrn_recurrence_unit_state_rf.sv | 29 ++
 rtl/sigmoid_unit.sv | 20 ++
 rtl/hgrn_recurrence_unit.sv | 105 ++++++++++
 tb/tb_hgrn_recurrence_unit.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/hgrn_recurrence_unit_pkg.sv
// hgrn_recurrence_unit_pkg: shared signed Q(N-R).R fixed-point types and rounding/saturation helper
package hgrn_recurrence_unit_pkg;

    localparam int FXP_N   = 16;
    localparam int FXP_R   = 6;
    localparam int FXP_ONE = 1 << FXP_R;
    localparam int ACC_W   = 2 * FXP_N + 1;

    typedef logic signed [FXP_N-1:0] fxp_t;
    typedef logic signed [ACC_W-1:0] acc_t;

    localparam acc_t FXP_MAX = acc_t'((1 << (FXP_N - 1)) - 1);
    localparam acc_t FXP_MIN = acc_t'(-(1 << (FXP_N - 1)));

    // Round half up at the R-bit fraction boundary, then clamp to the fxp_t range
    function automatic fxp_t fxp_round_sat(input acc_t acc);
        acc_t r;
        r = (acc + acc_t'(FXP_ONE / 2)) >>> FXP_R;
        return (r > FXP_MAX) ? fxp_t'(FXP_MAX) : (r < FXP_MIN) ? fxp_t'(FXP_MIN) : fxp_t'(r);
    endfunction

endpackage

// File: rtl/hgrn_recurrence_unit_state_rf.sv
// hgrn_state_rf: D x N hidden-state register file, one combinational read, one write
module hgrn_state_rf #(
    parameter int N    = 16,
    parameter int D    = 64,
    parameter int CH_W = $clog2(D)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [CH_W-1:0] rd_addr,
    output logic [N-1:0]    rd_data,
    input  logic            we,
    input  logic [CH_W-1:0] wr_addr,
    input  logic [N-1:0]    wr_data
);

    logic [N-1:0] mem [D];

    assign rd_data = mem[rd_addr];

    // Whole state clears on reset so a new stream starts from h = 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < D; i++) mem[i] <= '0;
        end else if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

endmodule

// File: rtl/sigmoid_unit.sv
// sigmoid_unit: hard-sigmoid approximation clamp(x/4 + 0.5, 0, 1) in signed Q(N-R).R
module sigmoid_unit #(
    parameter int N = 16,
    parameter int R = 6
) (
    input  logic signed [N-1:0] x,
    output logic signed [N-1:0] y
);

    localparam logic signed [N:0] ONE_S = (N+1)'(1 << R);

    logic signed [N:0] t;

    // Widen by one bit so the +0.5 offset cannot wrap before clamping
    always_comb begin
        t = ($signed({x[N-1], x}) >>> 2) + (N+1)'(1 << (R - 1));
        y = t[N] ? '0 : (t > ONE_S) ? N'(1 << R) : t[N-1:0];
    end

endmodule

// File: rtl/hgrn_recurrence_unit.sv
// hgrn_recurrence_unit: channel-major HGRN recurrence h = f*h_prev + (1-f)*c with f = sigmoid(f_pre)
module hgrn_recurrence_unit
    import hgrn_recurrence_unit_pkg::*;
#(
    parameter int N    = FXP_N,
    parameter int R    = FXP_R,
    parameter int D    = 64,
    parameter int CH_W = $clog2(D)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N-1:0]    f_pre,
    input  logic [N-1:0]    c_in,
    input  logic            seq_start,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N-1:0]    h_out,
    output logic [CH_W-1:0] out_ch,
    output logic            out_last
);

    if (D < 4) begin : g_bad_d
        $error("hgrn_recurrence_unit: D must be at least 4");
    end
    if (N != FXP_N || R != FXP_R) begin : g_bad_fmt
        $error("hgrn_recurrence_unit: N/R must match the shared fixed-point format");
    end

    logic [CH_W-1:0] ch, s1_ch;
    logic            seq, s1_v, adv, accept, use_zero, we;
    fxp_t            fs, h_rd, s1_fs, s1_c, s1_h, om, res;
    acc_t            acc;

    sigmoid_unit #(.N(N), .R(R)) u_sig (
        .x (f_pre),
        .y (fs)
    );

    hgrn_state_rf #(.N(N), .D(D), .CH_W(CH_W)) u_rf (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_addr (ch),
        .rd_data (h_rd),
        .we      (we),
        .wr_addr (s1_ch),
        .wr_data (res)
    );

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign accept   = in_valid && adv;
    assign use_zero = (ch == '0) ? seq_start : seq;
    assign we       = adv && s1_v;
    assign om       = fxp_t'(1 << R) - s1_fs;
    assign acc      = acc_t'(s1_fs) * acc_t'(s1_h) + acc_t'(om) * acc_t'(s1_c);
    assign res      = fxp_round_sat(acc);

    // Channel counter and per-token sequence flag latched on the channel-0 beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch  <= '0;
            seq <= 1'b0;
        end else if (accept) begin
            ch <= (ch == CH_W'(D - 1)) ? '0 : ch + 1'b1;
            if (ch == '0) seq <= seq_start;
        end
    end

    // Stage 1: capture gate, candidate, channel and previous state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v  <= 1'b0;
            s1_fs <= '0;
            s1_c  <= '0;
            s1_ch <= '0;
            s1_h  <= '0;
        end else if (adv) begin
            s1_v  <= accept;
            s1_fs <= fs;
            s1_c  <= c_in;
            s1_ch <= ch;
            s1_h  <= use_zero ? '0 : h_rd;
        end
    end

    // Stage 2: output register, updated together with the state writeback
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            h_out     <= '0;
            out_ch    <= '0;
            out_last  <= 1'b0;
        end else if (adv) begin
            out_valid <= s1_v;
            if (s1_v) begin
                h_out    <= res;
                out_ch   <= s1_ch;
                out_last <= (s1_ch == CH_W'(D - 1));
            end
        end
    end

endmodule

// File: tb/tb_hgrn_recurrence_unit.sv
// tb_hgrn_recurrence_unit: directed checks of the HGRN recurrence unit
module tb_hgrn_recurrence_unit;

    localparam int D = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] f_pre;
    logic [15:0] c_in;
    logic        seq_start;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] h_out;
    logic [5:0]  out_ch;
    logic        out_last;

    int checks = 0;
    int errors = 0;

    hgrn_recurrence_unit #(.N(16), .R(6), .D(D)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .f_pre     (f_pre),
        .c_in      (c_in),
        .seq_start (seq_start),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .h_out     (h_out),
        .out_ch    (out_ch),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One full token of D beats with constant f/c; seq_start on beat seq_ch; optional 5-cycle stall
    task automatic token(input string tag, input int f, input int c, input int seq_ch,
                         input int stall_at, input int exp);
        int gh [D];
        int gc [D];
        int gl [D];
        int sent, got, cyc, stall_left, t_acc, t_val, hold_h, hold_ch;
        bit stalled;
        sent = 0; got = 0; cyc = 0; stall_left = 0; t_acc = -1; t_val = -1;
        hold_h = 0; hold_ch = 0; stalled = 0;
        while (got < D && cyc < 1000) begin
            @(negedge clk);
            if (stall_at >= 0 && sent == stall_at && !stalled) begin
                stalled = 1;
                stall_left = 5;
            end
            out_ready = (stall_left == 0);
            in_valid  = (sent < D);
            f_pre     = 16'(f);
            c_in      = 16'(c);
            seq_start = (sent == seq_ch);
            #1;
            if (stall_left > 0) begin
                if (stall_left == 5) begin
                    hold_h  = int'(h_out);
                    hold_ch = int'(out_ch);
                end else begin
                    check({tag, " stall h_out"}, int'(h_out), hold_h);
                    check({tag, " stall out_ch"}, int'(out_ch), hold_ch);
                end
                check({tag, " stall out_valid"}, int'(out_valid), 1);
                check({tag, " stall in_ready"}, int'(in_ready), 0);
                stall_left--;
            end
            if (out_valid && t_val < 0) t_val = cyc;
            if (in_valid && in_ready) begin
                if (t_acc < 0) t_acc = cyc;
                sent++;
            end
            if (out_valid && out_ready) begin
                gh[got] = int'($signed(h_out));
                gc[got] = int'(out_ch);
                gl[got] = int'(out_last);
                got++;
            end
            cyc++;
        end
        in_valid = 1'b0; seq_start = 1'b0; out_ready = 1'b1;
        check({tag, " output count"}, got, D);
        check({tag, " latency"}, t_val - t_acc, 2);
        for (int i = 0; i < got; i++) begin
            check($sformatf("%s h ch%0d", tag, i), gh[i], exp);
            check($sformatf("%s out_ch beat%0d", tag, i), gc[i], i);
            check($sformatf("%s out_last beat%0d", tag, i), gl[i], (i == D - 1) ? 1 : 0);
        end
        repeat (3) @(negedge clk);
        check({tag, " no extra output"}, int'(out_valid), 0);
    endtask

    initial begin
        int sent, cyc;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        f_pre = '0; c_in = '0; seq_start = 1'b0;
        repeat (2) @(negedge clk);
        check("reset out_valid", int'(out_valid), 0);
        check("reset h_out", int'(h_out), 0);
        check("reset out_ch", int'(out_ch), 0);
        check("reset out_last", int'(out_last), 0);
        check("reset in_ready", int'(in_ready), 1);
        rst_n = 1'b1;

        token("t1 seq", 0, 64, 0, -1, 32);
        token("t2 accum", 0, 64, -1, -1, 48);
        token("t3 reseq", 0, 64, 0, -1, 32);
        token("t4 stall", 0, 64, -1, 20, 48);
        token("t5 seq ch5", 0, 64, 5, -1, 56);
        token("t6 load max", -32768, 32767, -1, -1, 32767);
        token("t7 sat max", 0, 32767, -1, -1, 32767);
        token("t8 load min", -32768, -32768, -1, -1, -32768);
        token("t9 sat min", 0, -32768, -1, -1, -32768);
        token("t10 f high", 32767, 1000, -1, -1, -32768);
        token("t11 f neg", -40, 64, 0, -1, 42);

        sent = 0; cyc = 0;
        while (sent < 10 && cyc < 100) begin
            @(negedge clk);
            in_valid = 1'b1; f_pre = '0; c_in = 16'd64; seq_start = 1'b0; out_ready = 1'b1;
            #1;
            if (in_ready) sent++;
            cyc++;
        end
        check("pre-reset accepts", sent, 10);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("pre-reset out_valid", int'(out_valid), 1);
        #1 rst_n = 1'b0;
        #1;
        check("async reset out_valid", int'(out_valid), 0);
        check("async reset h_out", int'(h_out), 0);
        check("async reset out_ch", int'(out_ch), 0);
        check("async reset out_last", int'(out_last), 0);
        @(negedge clk);
        rst_n = 1'b1;

        token("t12 post reset", 0, 64, -1, -1, 32);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
